// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, state encoding and request record for the memory-access stage
package mem_stage_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int REG_W = 3;
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_e;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  rd;
  } req_t;
endpackage

// File: rtl/mem_access_stage.sv
// mem_access_stage: single-outstanding load/store stage driving a 256x16 data memory
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [REG_W-1:0]  req_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [REG_W-1:0]  rsp_rd,
  output logic              rsp_err,
  output logic              st_err,
  output logic [15:0]       ld_cnt,
  output logic [15:0]       st_cnt
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  state_e            state_q;
  req_t              req_q;
  logic              oor_q, mem_we_q, mem_re_q, rsp_valid_q, rsp_err_q, st_err_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [REG_W-1:0]  rsp_rd_q;
  logic [15:0]       ld_cnt_q, ld_cnt_d, st_cnt_q, st_cnt_d;
  logic              accept, req_oor, st_inc, ld_inc;
  assign req_ready = state_q == IDLE;
  assign accept    = req_valid && req_ready;
  assign req_oor   = {1'b0, req_addr} >= LIMIT;
  assign st_inc    = state_q == ACCESS && req_q.we && !oor_q;
  assign ld_inc    = state_q == RESP && rsp_ready;
  assign st_cnt_d  = st_cnt_q + 16'(st_inc);
  assign ld_cnt_d  = ld_cnt_q + 16'(ld_inc);
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_err   = rsp_err_q;
  assign st_err    = st_err_q;
  assign ld_cnt    = ld_cnt_q;
  assign st_cnt    = st_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      oor_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      rsp_err_q   <= 1'b0;
      st_err_q    <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      st_err_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          req_q.we <= req_we;
          req_q.rd <= req_rd;
          oor_q    <= req_oor;
          if (!req_oor) begin
            req_q.addr  <= req_addr;
            req_q.wdata <= req_wdata;
            mem_we_q    <= req_we;
            mem_re_q    <= !req_we;
          end
          state_q <= ACCESS;
        end
        ACCESS: begin
          st_err_q <= req_q.we && oor_q;
          state_q  <= req_q.we ? IDLE : CAPTURE;
        end
        CAPTURE: begin
          rsp_data_q  <= oor_q ? '0 : mem_rdata;
          rsp_err_q   <= oor_q;
          rsp_rd_q    <= req_q.rd;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    st_cnt_q <= rst ? '0 : st_cnt_d;
  end
  always_ff @(posedge clk) begin
    ld_cnt_q <= rst ? '0 : ld_cnt_d;
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed checks of the memory-access stage against a 256x16 memory model
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [2:0]  req_rd = '0;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we, mem_re;
  logic [15:0] mem_rdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_rd;
  logic        rsp_err, st_err;
  logic [15:0] ld_cnt, st_cnt;
  logic [15:0] mem [256];
  int          errors = 0;
  int          checks = 0;
  int          we_n = 0;
  int          re_n = 0;
  int          err_n = 0;
  mem_access_stage #(.DEPTH(200)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err), .st_err(st_err),
    .ld_cnt(ld_cnt), .st_cnt(st_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) we_n <= we_n + 1;
    if (mem_re) re_n <= re_n + 1;
    if (st_err) err_n <= err_n + 1;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic start(input logic we, input logic [7:0] addr, input logic [15:0] wdata, input logic [2:0] rd);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rd;
    step();
    req_valid = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    repeat (3) step();
    rst = 1'b0;
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_rd", rsp_rd, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_st_err", st_err, 0);
    check("rst_ld_cnt", ld_cnt, 0);
    check("rst_st_cnt", st_cnt, 0);
    start(1'b1, 8'h05, 16'hBEEF, 3'd0);
    check("st_we_t1", mem_we, 1);
    check("st_addr_t1", mem_addr, 8'h05);
    check("st_wdata_t1", mem_wdata, 16'hBEEF);
    check("st_ready_t1", req_ready, 0);
    step();
    check("st_we_t2", mem_we, 0);
    check("st_ready_t2", req_ready, 1);
    check("st_cnt_1", st_cnt, 1);
    start(1'b0, 8'h05, 16'h0000, 3'd3);
    check("ld_re_t1", mem_re, 1);
    check("ld_addr_t1", mem_addr, 8'h05);
    step();
    check("ld_re_t2", mem_re, 0);
    check("ld_valid_t2", rsp_valid, 0);
    step();
    check("ld_valid_t3", rsp_valid, 1);
    check("ld_data_t3", rsp_data, 16'hBEEF);
    check("ld_rd_t3", rsp_rd, 3);
    check("ld_err_t3", rsp_err, 0);
    step();
    check("ld_valid_t4", rsp_valid, 0);
    check("ld_ready_t4", req_ready, 1);
    check("ld_cnt_1", ld_cnt, 1);
    check("st_cnt_still_1", st_cnt, 1);
    rsp_ready = 1'b0;
    start(1'b0, 8'h10, 16'h0000, 3'd5);
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, 16'h1010);
      check("stall_rd", rsp_rd, 5);
      check("stall_ready", req_ready, 0);
      check("stall_ld_cnt", ld_cnt, 1);
      if (k < 4) step();
    end
    rsp_ready = 1'b1;
    step();
    check("release_valid", rsp_valid, 0);
    check("release_ready", req_ready, 1);
    check("release_ld_cnt", ld_cnt, 2);
    step();
    check("release_ld_cnt_once", ld_cnt, 2);
    start(1'b1, 8'hC8, 16'h1234, 3'd0);
    check("oor_st_we", mem_we, 0);
    check("oor_st_addr_hold", mem_addr, 8'h10);
    step();
    check("oor_st_err", st_err, 1);
    check("oor_st_ready", req_ready, 1);
    check("oor_st_cnt", st_cnt, 1);
    start(1'b0, 8'hFF, 16'h0000, 3'd6);
    check("oor_ld_re", mem_re, 0);
    check("oor_st_err_clear", st_err, 0);
    step();
    step();
    check("oor_ld_valid", rsp_valid, 1);
    check("oor_ld_err", rsp_err, 1);
    check("oor_ld_data", rsp_data, 0);
    check("oor_ld_rd", rsp_rd, 6);
    step();
    check("oor_ld_cnt", ld_cnt, 3);
    check("we_pulses", we_n, 1);
    check("re_pulses", re_n, 2);
    check("st_err_pulses", err_n, 1);
    start(1'b0, 8'h05, 16'h0000, 3'd2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_ld_cnt", ld_cnt, 0);
    check("mid_rst_st_cnt", st_cnt, 0);
    check("mid_rst_data", rsp_data, 0);
    check("mid_rst_rd", rsp_rd, 0);
    check("mid_rst_mem_re", mem_re, 0);
    step();
    step();
    check("mid_rst_no_rsp", rsp_valid, 0);
    force dut.st_cnt_q = 16'hFFFF;
    step();
    release dut.st_cnt_q;
    step();
    start(1'b1, 8'h07, 16'hAAAA, 3'd0);
    step();
    check("wrap_st_cnt", st_cnt, 0);
    check("wrap_ready", req_ready, 1);
    start(1'b1, 8'h08, 16'h5555, 3'd0);
    step();
    check("b2b_st_cnt", st_cnt, 1);
    start(1'b0, 8'h07, 16'h0000, 3'd1);
    step();
    step();
    check("rd_back_data", rsp_data, 16'hAAAA);
    check("rd_back_rd", rsp_rd, 1);
    step();
    check("rd_back_ld_cnt", ld_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
